// File: rtl/micro86_bus_pkg.sv
// Shared definitions for the micro86 memory-bus initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package micro86_bus_pkg;

   localparam int BUS_ADDR_W = 16;
   localparam int BUS_DATA_W = 8;

   // Byte sequencer states of the bus master.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BYTE0 = 2'd1,
      BYTE1 = 2'd2,
      RESP  = 2'd3
   } bus_state_t;

endpackage

// File: rtl/mem_bus_master.sv
// Turns 8/16-bit CPU loads/stores into little-endian byte accesses on the 8-bit memory bus.
// Latency: byte load 3 cycles accept->rsp, word load 5, byte store 2, word store 3 (READ_LATENCY=1, no waits).
// Backpressure: bus_ready=0 stretches the current byte; TIMEOUT wait cycles abort it; req_ready only in IDLE.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready handshake with req_write, req_word, req_address, req_data
//   rsp_valid one-cycle pulse with rsp_data, rsp_error (timeout abort)
//   bus_address, bus_data_out, bus_enable, bus_write_enable to the bus; bus_data_in, bus_ready from it
module mem_bus_master
   import micro86_bus_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int TIMEOUT      = 255
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic                  req_word,
   input  logic [BUS_ADDR_W-1:0] req_address,
   input  logic [15:0]           req_data,
   output logic                  rsp_valid,
   output logic [15:0]           rsp_data,
   output logic                  rsp_error,
   output logic [BUS_ADDR_W-1:0] bus_address,
   output logic [BUS_DATA_W-1:0] bus_data_out,
   input  logic [BUS_DATA_W-1:0] bus_data_in,
   output logic                  bus_enable,
   output logic                  bus_write_enable,
   input  logic                  bus_ready
);

   localparam logic [7:0] RD_LAT = 8'(READ_LATENCY);
   localparam logic [7:0] TMO    = 8'(TIMEOUT);

   bus_state_t      state;
   bus_state_t      state_nxt;
   logic [7:0]      wait_cnt;
   logic [15:0]     addr_q;
   logic [15:0]     wdata_q;
   logic [15:0]     rdata_q;
   logic            write_q;
   logic            word_q;
   logic            err_q;
   logic            in_byte;
   logic            byte_done;
   logic            byte_abort;

   assign in_byte    = (state == BYTE0) || (state == BYTE1);
   // Stores complete on the first ready cycle; loads must also have held
   // the address for the read-latency budget.
   assign byte_done  = in_byte && bus_ready && (write_q || (wait_cnt >= RD_LAT));
   // A byte that completes on its last allowed cycle is not aborted.
   assign byte_abort = in_byte && !byte_done && (wait_cnt == TMO);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus all outputs; outputs depend on state and latched
   // registers only, never on live req_* or bus_* inputs.
   always_comb begin
      state_nxt        = state;
      req_ready        = 1'b0;
      rsp_valid        = 1'b0;
      rsp_error        = 1'b0;
      rsp_data         = '0;
      bus_enable       = 1'b0;
      bus_write_enable = 1'b0;
      bus_address      = addr_q;
      bus_data_out     = wdata_q[7:0];
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = BYTE0;
         end
         BYTE0: begin
            bus_enable       = 1'b1;
            bus_write_enable = write_q;
            if (byte_done)       state_nxt = word_q ? BYTE1 : RESP;
            else if (byte_abort) state_nxt = RESP;
         end
         BYTE1: begin
            bus_enable       = 1'b1;
            bus_write_enable = write_q;
            bus_address      = addr_q + 16'd1;   // wraps 0xFFFF -> 0x0000
            bus_data_out     = wdata_q[15:8];
            if (byte_done || byte_abort) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_error = err_q;
            rsp_data  = err_q ? 16'h0000 : rdata_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         write_q  <= 1'b0;
         word_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         // Counter restarts on every byte boundary (any state change).
         if (state != state_nxt)  wait_cnt <= '0;
         else if (in_byte)        wait_cnt <= wait_cnt + 8'd1;

         if (state == IDLE && req_valid) begin
            addr_q  <= req_address;
            wdata_q <= req_data;
            write_q <= req_write;
            word_q  <= req_word;
            rdata_q <= '0;        // gives zero-extension and a zero store result
            err_q   <= 1'b0;
         end

         if (byte_done && !write_q) begin
            if (state == BYTE0) rdata_q[7:0]  <= bus_data_in;
            else                rdata_q[15:8] <= bus_data_in;
         end

         if (byte_abort) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: per-transaction timeline model vs. DUT every cycle.
// Latency: n/a.
// Backpressure: bench drives bus_ready from a per-transaction pattern.
module tb_mem_bus_master;

   localparam int RL   = 1;
   localparam int TMO  = 4;
   localparam int MAXC = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_word;
   logic [15:0] req_address;
   logic [15:0] req_data;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_error;
   logic [15:0] bus_address;
   logic [7:0]  bus_data_out;
   logic [7:0]  bus_data_in;
   logic        bus_enable;
   logic        bus_write_enable;
   logic        bus_ready;

   mem_bus_master #(.READ_LATENCY(RL), .TIMEOUT(TMO)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_word         (req_word),
      .req_address      (req_address),
      .req_data         (req_data),
      .rsp_valid        (rsp_valid),
      .rsp_data         (rsp_data),
      .rsp_error        (rsp_error),
      .bus_address      (bus_address),
      .bus_data_out     (bus_data_out),
      .bus_data_in      (bus_data_in),
      .bus_enable       (bus_enable),
      .bus_write_enable (bus_write_enable),
      .bus_ready        (bus_ready)
   );

   always #5 clk = ~clk;

   // Memory behind the bus responder.
   logic [7:0] mem [0:65535];
   assign bus_data_in = mem[bus_address];

   int vectors    = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Current transaction and its predicted timeline (index = cycles after c0).
   logic        t_write, t_word;
   logic [15:0] t_addr, t_data;
   logic        rdy     [MAXC];
   logic        exp_en  [MAXC];
   logic        exp_we  [MAXC];
   logic [15:0] exp_addr[MAXC];
   logic [7:0]  exp_dout[MAXC];
   int          exp_rsp_cyc;
   logic [15:0] exp_rsp_data;
   logic        exp_err;
   int          wr_n;
   logic [15:0] wr_a[2];
   logic [7:0]  wr_d[2];

   // Walk the byte accesses: each byte starts the cycle after the previous
   // finished, ends on the first ready cycle that meets its latency, or is
   // abandoned after TMO+1 cycles which also ends the whole access.
   task automatic predict();
      int          cyc;
      logic [15:0] res;
      bit          abort;
      for (int i = 0; i < MAXC; i++) begin
         exp_en[i] = 1'b0; exp_we[i] = 1'b0; exp_addr[i] = '0; exp_dout[i] = '0;
      end
      cyc = 1; res = '0; abort = 0; wr_n = 0;
      for (int b = 0; b < (t_word ? 2 : 1) && !abort; b++) begin
         int          minlat;
         int          k;
         logic [15:0] a;
         minlat = t_write ? 0 : RL;
         a      = t_addr + 16'(b);
         k      = 0;
         while (1) begin
            exp_en[cyc+k]   = 1'b1;
            exp_we[cyc+k]   = t_write;
            exp_addr[cyc+k] = a;
            exp_dout[cyc+k] = (b == 1) ? t_data[15:8] : t_data[7:0];
            if (rdy[cyc+k] && k >= minlat) begin
               if (t_write) begin
                  wr_a[wr_n] = a; wr_d[wr_n] = exp_dout[cyc+k]; wr_n++;
               end else begin
                  res[8*b +: 8] = mem[a];
               end
               break;
            end
            if (k == TMO) begin
               abort = 1;
               break;
            end
            k++;
         end
         cyc += k + 1;
      end
      exp_rsp_cyc  = cyc;
      exp_err      = abort;
      exp_rsp_data = (abort || t_write) ? 16'h0000 : res;
   endtask

   // Observations for the literal checks of directed cases.
   int          txn_cyc = 0;
   bit          active  = 0;
   int          obs_rsp_cyc;
   logic [15:0] obs_rsp_data;
   logic        obs_err;
   int          obs_en_cnt;
   int          obs_wr_n;
   logic [15:0] obs_wr_a[4];
   logic [7:0]  obs_wr_d[4];

   // Single compare process: DUT against the predicted timeline each cycle.
   always @(negedge clk) begin
      if (active) begin
         check("bus_enable",       32'(bus_enable),       32'(exp_en[txn_cyc]));
         check("bus_write_enable", 32'(bus_write_enable), 32'(exp_we[txn_cyc]));
         if (exp_en[txn_cyc]) check("bus_address", 32'(bus_address), 32'(exp_addr[txn_cyc]));
         if (exp_we[txn_cyc]) check("bus_data_out", 32'(bus_data_out), 32'(exp_dout[txn_cyc]));
         check("rsp_valid", 32'(rsp_valid), 32'(txn_cyc == exp_rsp_cyc));
         check("req_ready", 32'(req_ready), 32'(txn_cyc == 0 || txn_cyc > exp_rsp_cyc));
         if (txn_cyc == exp_rsp_cyc) begin
            check("rsp_data",  32'(rsp_data),  32'(exp_rsp_data));
            check("rsp_error", 32'(rsp_error), 32'(exp_err));
         end
         if (rsp_valid) begin
            obs_rsp_cyc = txn_cyc; obs_rsp_data = rsp_data; obs_err = rsp_error;
         end
         if (bus_enable) obs_en_cnt++;
         if (bus_enable && bus_write_enable && bus_ready && obs_wr_n < 4) begin
            obs_wr_a[obs_wr_n] = bus_address; obs_wr_d[obs_wr_n] = bus_data_out; obs_wr_n++;
         end
      end
   end

   task automatic set_rdy(input int mode);
      for (int i = 0; i < MAXC; i++) begin
         case (mode)
            0:       rdy[i] = 1'b1;
            1:       rdy[i] = 1'b0;
            2:       rdy[i] = ($urandom_range(0, 3) != 0);
            default: rdy[i] = ($urandom_range(0, 1) != 0);
         endcase
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " req_ready"},        32'(req_ready),        32'd1);
      check({tag, " rsp_valid"},        32'(rsp_valid),        32'd0);
      check({tag, " rsp_data"},         32'(rsp_data),         32'd0);
      check({tag, " rsp_error"},        32'(rsp_error),        32'd0);
      check({tag, " bus_address"},      32'(bus_address),      32'd0);
      check({tag, " bus_data_out"},     32'(bus_data_out),     32'd0);
      check({tag, " bus_enable"},       32'(bus_enable),       32'd0);
      check({tag, " bus_write_enable"}, 32'(bus_write_enable), 32'd0);
   endtask

   // Runs one request; rdy[] must be set by the caller. reset_at >= 0 pulls
   // reset at that cycle and abandons the access.
   task automatic run_txn(input logic w, input logic wd, input logic [15:0] a,
                          input logic [15:0] d, input int reset_at);
      t_write = w; t_word = wd; t_addr = a; t_data = d;
      predict();
      obs_rsp_cyc = -1; obs_rsp_data = 'x; obs_err = 'x; obs_en_cnt = 0; obs_wr_n = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = w; req_word = wd; req_address = a; req_data = d;
      bus_ready = rdy[0];
      txn_cyc = 0; active = 1;
      for (int c = 1; c <= exp_rsp_cyc + 1; c++) begin
         @(posedge clk); #1;
         txn_cyc = c;
         bus_ready = rdy[c];
         if (c <= exp_rsp_cyc) begin
            // Busy: requests must be ignored.
            req_valid   = ($urandom_range(0, 1) != 0);
            req_write   = 1'($urandom);
            req_word    = 1'($urandom);
            req_address = 16'($urandom);
            req_data    = 16'($urandom);
         end else begin
            req_valid = 1'b0;
         end
         if (c == reset_at) begin
            active = 0;
            check("pre-reset bus_enable", 32'(bus_enable), 32'd1);
            reset = 1'b0;
            #1;
            check_reset_vals("mid-reset");
            @(negedge clk);
            check("mid-reset rsp_valid", 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
            check("held-reset rsp_valid", 32'(rsp_valid), 32'd0);
            check("held-reset req_ready", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            reset = 1'b1;
            return;
         end
      end
      @(posedge clk);
      active = 0;
      for (int i = 0; i < wr_n; i++) mem[wr_a[i]] = wr_d[i];
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
      req_address = '0; req_data = '0; bus_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk); #1;
      reset = 1'b1;

      // Byte load, no waits.
      mem[16'h0100] = 8'h5A;
      set_rdy(0);
      run_txn(1'b0, 1'b0, 16'h0100, 16'h0000, -1);
      check("byteload rsp cycle", 32'(obs_rsp_cyc), 32'd3);
      check("byteload rsp_data",  32'(obs_rsp_data), 32'h005A);
      check("byteload rsp_error", 32'(obs_err), 32'd0);
      check("byteload enable cycles", 32'(obs_en_cnt), 32'd2);

      // Word load across the address wrap.
      mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
      set_rdy(0);
      run_txn(1'b0, 1'b1, 16'hFFFF, 16'h0000, -1);
      check("wrapload rsp cycle", 32'(obs_rsp_cyc), 32'd5);
      check("wrapload rsp_data",  32'(obs_rsp_data), 32'h1234);

      // Word store.
      set_rdy(0);
      run_txn(1'b1, 1'b1, 16'hC010, 16'hBEEF, -1);
      check("wordstore rsp cycle", 32'(obs_rsp_cyc), 32'd3);
      check("wordstore rsp_data",  32'(obs_rsp_data), 32'd0);
      check("wordstore writes",    32'(obs_wr_n), 32'd2);
      check("wordstore addr0", 32'(obs_wr_a[0]), 32'hC010);
      check("wordstore data0", 32'(obs_wr_d[0]), 32'hEF);
      check("wordstore addr1", 32'(obs_wr_a[1]), 32'hC011);
      check("wordstore data1", 32'(obs_wr_d[1]), 32'hBE);

      // Word load with three wait cycles in the high byte.
      set_rdy(0);
      rdy[4] = 1'b0; rdy[5] = 1'b0; rdy[6] = 1'b0;
      run_txn(1'b0, 1'b1, 16'h2468, 16'h0000, -1);
      check("waitload rsp cycle", 32'(obs_rsp_cyc), 32'd8);
      check("waitload rsp_data",  32'(obs_rsp_data), 32'({mem[16'h2469], mem[16'h2468]}));

      // Timeout on a word load: bus never ready.
      set_rdy(1);
      run_txn(1'b0, 1'b1, 16'h3000, 16'h0000, -1);
      check("timeout rsp cycle", 32'(obs_rsp_cyc), 32'd6);
      check("timeout rsp_error", 32'(obs_err), 32'd1);
      check("timeout rsp_data",  32'(obs_rsp_data), 32'd0);
      check("timeout enable cycles", 32'(obs_en_cnt), 32'd5);

      // Reset in the first high-byte cycle of a word load, then a clean access.
      set_rdy(0);
      run_txn(1'b0, 1'b1, 16'h4000, 16'h0000, 3);
      mem[16'h4242] = 8'hC3;
      set_rdy(0);
      run_txn(1'b0, 1'b0, 16'h4242, 16'h0000, -1);
      check("post-reset rsp_data", 32'(obs_rsp_data), 32'h00C3);
      check("post-reset rsp cycle", 32'(obs_rsp_cyc), 32'd3);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         logic [15:0] a;
         int          mode;
         a    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         mode = ($urandom_range(0, 15) == 0) ? 1 : $urandom_range(0, 3);
         if (mode == 1) mode = ($urandom_range(0, 1) != 0) ? 1 : 2;
         set_rdy(mode);
         run_txn(1'($urandom), 1'($urandom), a, 16'($urandom), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
